// File: rtl/fir_datapath_if.sv
// Micro-op bus between the FIR controller and the datapath execution unit.
// The controller drives op/operand selects and external words; the datapath answers with R0 and flags.
interface fir_datapath_if;
    logic [2:0]  op;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic [3:0]  dest;
    logic [15:0] ext_data1;
    logic [15:0] ext_data2;
    logic [15:0] outreg_data;
    logic        overflow;
    logic        illegal_op;

    modport master (
        output op, src1, src2, dest, ext_data1, ext_data2,
        input  outreg_data, overflow, illegal_op
    );

    modport slave (
        input  op, src1, src2, dest, ext_data1, ext_data2,
        output outreg_data, overflow, illegal_op
    );
endinterface

// File: rtl/fir_datapath.sv
// FIR datapath: 16x16-bit register file plus single-cycle ALU (copy/load/add/sub/Q1.15 mul).
// Define FIR_DP_SATURATE_EN to clamp overflowing results instead of writing the wrapped value.
module fir_datapath (
    input  logic          clk,
    input  logic          n_rst,
    fir_datapath_if.slave bus
);
    typedef enum logic [2:0] {
        OP_NOP   = 3'b000,
        OP_COPY  = 3'b001,
        OP_LOAD1 = 3'b010,
        OP_LOAD2 = 3'b011,
        OP_ADD   = 3'b100,
        OP_SUB   = 3'b101,
        OP_MUL   = 3'b110,
        OP_RSV   = 3'b111
    } op_e;

    typedef struct packed {
        logic        wr;
        logic [15:0] data;
        logic        ovf;
    } alu_res_t;

    logic [15:0][15:0] regs;
    logic              illegal_q;
    op_e               op;
    logic [15:0]       opa;
    logic [15:0]       opb;
    logic [15:0]       sum;
    logic [15:0]       diff;
    logic [31:0]       prod;
    logic [16:0]       prod_hi;
    logic              ovf_add;
    logic              ovf_sub;
    alu_res_t          res;

    assign op = op_e'(bus.op);

    // Reads are combinational and see pre-edge register contents.
    assign opa     = regs[bus.src1];
    assign opb     = regs[bus.src2];
    assign sum     = opa + opb;
    assign diff    = opa - opb;
    assign prod    = 32'(opa) * 32'(opb);
    assign prod_hi = 17'(prod >> 15);

    assign ovf_add = (opa[15] == opb[15]) && (sum[15]  != opa[15]);
    assign ovf_sub = (opa[15] != opb[15]) && (diff[15] != opa[15]);

    always_comb begin
        res      = '0;
        res.data = opa;
        unique case (op)
            OP_COPY: begin
                res.wr   = 1'b1;
                res.data = opa;
            end
            OP_LOAD1: begin
                res.wr   = 1'b1;
                res.data = bus.ext_data1;
            end
            OP_LOAD2: begin
                res.wr   = 1'b1;
                res.data = bus.ext_data2;
            end
            OP_ADD: begin
                res.wr   = 1'b1;
                res.ovf  = ovf_add;
                res.data = sum;
`ifdef FIR_DP_SATURATE_EN
                // On signed overflow the true result has the sign of src1.
                if (ovf_add) res.data = opa[15] ? 16'h8000 : 16'h7FFF;
`endif
            end
            OP_SUB: begin
                res.wr   = 1'b1;
                res.ovf  = ovf_sub;
                res.data = diff;
`ifdef FIR_DP_SATURATE_EN
                if (ovf_sub) res.data = opa[15] ? 16'h8000 : 16'h7FFF;
`endif
            end
            OP_MUL: begin
                res.wr   = 1'b1;
                res.ovf  = prod_hi[16];
                res.data = prod_hi[15:0];
`ifdef FIR_DP_SATURATE_EN
                if (prod_hi[16]) res.data = 16'hFFFF;
`endif
            end
            default: begin
                res.wr = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            regs      <= '0;
            illegal_q <= 1'b0;
        end else begin
            if (res.wr) regs[bus.dest] <= res.data;
            illegal_q <= (op == OP_RSV);
        end
    end

    assign bus.outreg_data = regs[0];
    assign bus.overflow    = res.ovf;
    assign bus.illegal_op  = illegal_q;
endmodule
